// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg : widths and types shared by the UART datapath and its divider
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   localparam int UART_PRESC_W = 16;

   typedef logic [UART_PRESC_W-1:0] presc_t;

endpackage

`default_nettype wire

// File: rtl/clock_divider.sv
// ----------------------------------------------------------------------------
// clock_divider : 50 % duty programmable divider with a rise-aligned tick
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clock_divider
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_PRESC_W
) (
   input  logic             clock_devided,
   input  logic [WIDTH-1:0] prescaler,
   output logic             clk_out,
   input  logic             reset,
   output logic             tick
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] p_sh;
   logic             terminal;

   assign terminal = (cnt == p_sh);

   // The prescaler is latched only at terminal count, so a half-period in
   // progress is never shortened or stretched by a live update.
   always_ff @(posedge clock_devided) begin
      if (!reset) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         p_sh    <= prescaler;
      end else if (terminal) begin
         cnt     <= '0;
         clk_out <= ~clk_out;
         p_sh    <= prescaler;
         tick    <= ~clk_out;
      end else begin
         cnt     <= cnt + ONE;
         tick    <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_clock_divider.sv
// ----------------------------------------------------------------------------
// tb_clock_divider : scoreboard bench, half-period countdown reference model
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_clock_divider;
   import uart_pkg::*;

   localparam int W = UART_PRESC_W;

   logic         clock_devided = 1'b0;
   logic         reset         = 1'b0;
   logic [W-1:0] prescaler     = '0;
   logic         clk_out;
   logic         tick;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic c;
      logic t;
   } exp_t;

   exp_t sb[$];

   clock_divider #(.WIDTH(W)) dut (
      .clock_devided (clock_devided),
      .prescaler     (prescaler),
      .clk_out       (clk_out),
      .reset         (reset),
      .tick          (tick)
   );

   always #5 clock_devided = ~clock_devided;

   // Reference: each half-period lasts (prescaler sampled at its start)+1 edges.
   initial begin : model
      logic lvl;
      int   rem;
      exp_t e;
      lvl = 1'b0;
      rem = 0;
      forever begin
         @(posedge clock_devided);
         e.t = 1'b0;
         if (!reset) begin
            lvl = 1'b0;
            rem = int'(prescaler) + 1;
         end else begin
            rem = rem - 1;
            if (rem == 0) begin
               lvl = ~lvl;
               rem = int'(prescaler) + 1;
               e.t = lvl;
            end
         end
         e.c = lvl;
         sb.push_back(e);
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock_devided);
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty at %0t: got clk_out/tick %b/%b want an expected entry",
                     $time, clk_out, tick);
         end else begin
            e = sb.pop_front();
            if (clk_out !== e.c || tick !== e.t) begin
               miscompares++;
               $display("FAIL cycle at %0t: clk_out/tick got %b/%b want %b/%b",
                        $time, clk_out, tick, e.c, e.t);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock_devided);
         #1;
      end
   endtask

   // Counts edges until clk_out is seen high, bounded.
   task automatic wait_rise(input int exp_n, input string name);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      for (int i = 1; i <= 70000 && !seen; i++) begin
         @(posedge clock_devided);
         #1;
         n = i;
         if (clk_out === 1'b1) seen = 1'b1;
      end
      vectors++;
      if (!seen || n != exp_n) begin
         miscompares++;
         $display("FAIL %s edges_to_rise got %0d (seen=%0d) want %0d", name, n, seen, exp_n);
      end
   endtask

   // Called on the rise sample; counts cycles clk_out stays high, bounded.
   task automatic count_high(input int exp_n, input string name);
      int n;
      bit fell;
      n    = 1;
      fell = 1'b0;
      for (int i = 0; i < 70000 && !fell; i++) begin
         @(posedge clock_devided);
         #1;
         if (clk_out === 1'b1) n++;
         else fell = 1'b1;
      end
      vectors++;
      if (!fell || n != exp_n) begin
         miscompares++;
         $display("FAIL %s high_cycles got %0d (fell=%0d) want %0d", name, n, fell, exp_n);
      end
   endtask

   initial begin : stim
      // P=0: divide by 2
      reset = 1'b0; prescaler = '0;
      cyc(2);
      reset = 1'b1;
      wait_rise(1, "p0_first_rise");
      cyc(10);

      // P=3: first rise on the 4th edge, 4 high / 4 low
      reset = 1'b0; prescaler = 16'd3;
      cyc(2);
      reset = 1'b1;
      wait_rise(4, "p3_first_rise");
      count_high(4, "p3_high");
      cyc(20);

      // P=9, then change to 1 in the middle of a half-period
      reset = 1'b0; prescaler = 16'd9;
      cyc(2);
      reset = 1'b1;
      cyc(13);
      prescaler = 16'd1;
      cyc(30);

      // P=5, reset during high phase
      reset = 1'b0; prescaler = 16'd5;
      cyc(2);
      reset = 1'b1;
      wait_rise(6, "p5_first_rise");
      cyc(2);
      reset = 1'b0;
      cyc(1);
      vectors++;
      if (clk_out !== 1'b0 || tick !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset clk_out/tick got %b/%b want 0/0", clk_out, tick);
      end
      reset = 1'b1;
      wait_rise(6, "p5_rise_after_reset");
      cyc(8);

      // Randomized prescaler updates and occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom % 8 == 0) begin
            if ($urandom % 4 == 0) prescaler = W'($urandom_range(0, 40));
            else                   prescaler = W'($urandom_range(0, 7));
         end
         reset = ($urandom % 200 != 0);
         cyc(1);
      end

      // P=0xFFFF high phase: entered from P=0 so the low phase is one cycle
      reset = 1'b0; prescaler = '0;
      cyc(2);
      reset = 1'b1; prescaler = 16'hFFFF;
      wait_rise(1, "pmax_rise");
      count_high(65536, "pmax_high");
      reset = 1'b0; prescaler = 16'd2;
      cyc(3);
      reset = 1'b1;
      cyc(12);

      @(negedge clock_devided);
      #1;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain pending got %0d want 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
